// File: rtl/uart_receiver.sv
// UART receiver: 2-flop synchronised rxd, LSB-first byte reassembly, one-cycle result pulses.
// Optional even-parity bit between data and stop when UART_RX_PARITY_EN is defined.
module uart_receiver #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 SW,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] word,
  output logic                 recieve_ready,
  output logic                 framing_error,
  output logic                 parity_error,
  output logic                 busy
);

  localparam int H  = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
`endif

  state_t               state;
  logic                 rxd_m, rxd_s;
  logic [CW-1:0]        clk_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 at_bit;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit;
`endif

  // Full-bit sample point; START uses its own half-bit compare.
  assign at_bit = (clk_cnt == CW'(CLKS_PER_BIT - 1));
  assign busy   = (state != IDLE);

`ifndef UART_RX_PARITY_EN
  assign parity_error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rxd_m         <= 1'b1;
      rxd_s         <= 1'b1;
      clk_cnt       <= '0;
      bit_cnt       <= '0;
      shreg         <= '0;
      word          <= '0;
      recieve_ready <= 1'b0;
      framing_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit       <= 1'b0;
      parity_error  <= 1'b0;
`endif
    end else begin
      rxd_m         <= rxd;
      rxd_s         <= rxd_m;
      recieve_ready <= 1'b0;
      framing_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_error  <= 1'b0;
`endif
      if (!SW) begin
        state   <= IDLE;
        clk_cnt <= '0;
        bit_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            clk_cnt <= '0;
            if (!rxd_s) state <= START;
          end
          START: begin
            if (clk_cnt == CW'(H - 1)) begin
              clk_cnt <= '0;
              bit_cnt <= '0;
              state   <= rxd_s ? IDLE : DATA;
            end else clk_cnt <= clk_cnt + 1'b1;
          end
          DATA: begin
            if (at_bit) begin
              clk_cnt <= '0;
              shreg   <= {rxd_s, shreg[DATA_BITS-1:1]};
              if (bit_cnt == BW'(DATA_BITS - 1)) begin
                bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                state   <= PARITY;
`else
                state   <= STOP;
`endif
              end else bit_cnt <= bit_cnt + 1'b1;
            end else clk_cnt <= clk_cnt + 1'b1;
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (at_bit) begin
              clk_cnt <= '0;
              par_bit <= rxd_s;
              state   <= STOP;
            end else clk_cnt <= clk_cnt + 1'b1;
          end
`endif
          STOP: begin
            if (at_bit) begin
              clk_cnt <= '0;
              if (rxd_s) begin
                state <= IDLE;
`ifdef UART_RX_PARITY_EN
                if (^{shreg, par_bit}) parity_error <= 1'b1;
                else begin
                  word          <= shreg;
                  recieve_ready <= 1'b1;
                end
`else
                word          <= shreg;
                recieve_ready <= 1'b1;
`endif
              end else begin
                framing_error <= 1'b1;
                state         <= BRK;
              end
            end else clk_cnt <= clk_cnt + 1'b1;
          end
          // Held-low line: wait for idle so it is not re-read as start bits.
          BRK: if (rxd_s) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
